target_tolerance_checker: RTL

//  Multi-axis "arrived at target" checker for the SCARA motion controller.

---
 rtl/target_tolerance_checker.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/target_tolerance_checker.sv
// Multi-axis "arrived at target" checker: a single shared subtractor visits one axis
// per cycle, and SETTLE consecutive all-in-tolerance passes declare arrival.
module target_tolerance_checker #(
    parameter int NAXES   = 2,
    parameter int W       = 32,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               relative,
    input  logic [NAXES*W-1:0] target,
    input  logic [NAXES*W-1:0] current,
    input  logic [W-2:0]       tol,
    output logic               busy,
    output logic               done,
    output logic               at_target,
    output logic               timed_out,
    output logic [NAXES-1:0]   axis_err_mask
);
    localparam int AXW = (NAXES > 1) ? $clog2(NAXES) : 1;
    localparam int SCW = $clog2(SETTLE + 1);
    localparam int CCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_r;
    logic [AXW-1:0]   axis_r;
    logic [SCW-1:0]   settle_cnt_r;
    logic [CCW-1:0]   cycle_cnt_r;
    logic [W:0]       eff_r [NAXES];
    logic [W-2:0]     tol_r;
    logic [NAXES-1:0] in_tol_r;

    logic [W-1:0]     cur_sel_s;
    logic [W:0]       eff_sel_s;
    logic [W+1:0]     diff_s;
    logic [W+1:0]     mag_s;
    logic             in_tol_s;
    logic             all_in_s;
    logic             settled_s;
    logic             timeout_hit_s;

    // Shared distance datapath for the axis being evaluated this cycle.
    // W+2 bits holds |(W+1)-bit target - W-bit position| without overflow.
    always_comb begin
        cur_sel_s = current[axis_r*W +: W];
        eff_sel_s = eff_r[axis_r];
        diff_s    = {eff_sel_s[W], eff_sel_s} - {{2{cur_sel_s[W-1]}}, cur_sel_s};
        if (diff_s[W+1]) begin
            mag_s = -diff_s;
        end else begin
            mag_s = diff_s;
        end
        in_tol_s = (mag_s <= {3'b000, tol_r});
    end

    // Pass-level decisions taken in CHECK.
    always_comb begin
        all_in_s      = &in_tol_r;
        settled_s     = all_in_s && (settle_cnt_r == SCW'(SETTLE - 1));
        timeout_hit_s = (TIMEOUT != 0) && (cycle_cnt_r >= CCW'(TIMEOUT));
    end

    // Control FSM with registered status and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            axis_r        <= '0;
            settle_cnt_r  <= '0;
            cycle_cnt_r   <= '0;
            tol_r         <= '0;
            in_tol_r      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            at_target     <= 1'b0;
            timed_out     <= 1'b0;
            axis_err_mask <= '0;
            for (int i = 0; i < NAXES; i++) begin
                eff_r[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (abort) begin
                // In IDLE abort only blocks a simultaneous start; results are kept.
                state_r      <= ST_IDLE;
                busy         <= 1'b0;
                axis_r       <= '0;
                settle_cnt_r <= '0;
                cycle_cnt_r  <= '0;
                if (state_r != ST_IDLE) begin
                    at_target     <= 1'b0;
                    timed_out     <= 1'b0;
                    axis_err_mask <= '0;
                end
            end else begin
                if (state_r == ST_EVAL || state_r == ST_CHECK) begin
                    if (cycle_cnt_r != {CCW{1'b1}}) begin
                        cycle_cnt_r <= cycle_cnt_r + CCW'(1);
                    end
                end
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            for (int i = 0; i < NAXES; i++) begin
                                if (relative) begin
                                    eff_r[i] <= {current[i*W+W-1], current[i*W +: W]}
                                              + {target[i*W+W-1], target[i*W +: W]};
                                end else begin
                                    eff_r[i] <= {target[i*W+W-1], target[i*W +: W]};
                                end
                            end
                            tol_r         <= tol;
                            axis_r        <= '0;
                            settle_cnt_r  <= '0;
                            cycle_cnt_r   <= '0;
                            at_target     <= 1'b0;
                            timed_out     <= 1'b0;
                            axis_err_mask <= '0;
                            busy          <= 1'b1;
                            state_r       <= ST_EVAL;
                        end
                    end
                    ST_EVAL: begin
                        in_tol_r[axis_r] <= in_tol_s;
                        if (axis_r == AXW'(NAXES - 1)) begin
                            axis_r  <= '0;
                            state_r <= ST_CHECK;
                        end else begin
                            axis_r <= axis_r + AXW'(1);
                        end
                    end
                    ST_CHECK: begin
                        axis_err_mask <= ~in_tol_r;
                        if (all_in_s) begin
                            settle_cnt_r <= settle_cnt_r + SCW'(1);
                        end else begin
                            settle_cnt_r <= '0;
                        end
                        // Success is tested first so it wins over a coincident timeout.
                        if (settled_s) begin
                            at_target <= 1'b1;
                            done      <= 1'b1;
                            state_r   <= ST_DONE;
                        end else if (timeout_hit_s) begin
                            timed_out <= 1'b1;
                            done      <= 1'b1;
                            state_r   <= ST_DONE;
                        end else begin
                            state_r <= ST_EVAL;
                        end
                    end
                    ST_DONE: begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
